// File: rtl/byte_serial_pkg.sv
// Shared definitions for the byte serial transmitter and its matching receiver.
package byte_serial_pkg;

   localparam int unsigned DATA_W      = 32'd8;
   localparam logic        IDLE_LEVEL  = 1'b1;
   localparam logic        START_LEVEL = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   // Even parity bit: makes the total count of ones (data + parity) even.
   function automatic logic even_parity(input logic [DATA_W-1:0] b);
      return ^b;
   endfunction

   // Bit timer width: enough bits to count 0..clks-1, never narrower than 1.
   function automatic int unsigned timer_w(input int unsigned clks);
      return (clks > 32'd1) ? $clog2(clks) : 32'd1;
   endfunction

endpackage

// File: rtl/byte_serial_tx_if.sv
// Byte handshake between the upstream data registers and the serial transmitter.
interface byte_serial_tx_if;
   import byte_serial_pkg::*;

   logic [DATA_W-1:0] Din;
   logic              din_valid;
   logic              din_ready;

   modport master (output Din, output din_valid, input  din_ready);
   modport slave  (input  Din, input  din_valid, output din_ready);

endinterface

// File: rtl/byte_serial_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module bit_timer
   import byte_serial_pkg::*;
#(
   parameter  int unsigned CLKS_PER_BIT = 32'd4,
   localparam int unsigned TW           = timer_w(CLKS_PER_BIT)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          en_i,
   output logic          tick_o,
   output logic [TW-1:0] cnt_o
);

   localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 32'd1);

   logic [TW-1:0] cnt_q;

   // Terminal count marks the last cycle of the current serial bit.
   always_comb begin
      tick_o = (cnt_q == TERM);
      cnt_o  = cnt_q;
   end

   // Free-running bit counter, wrapping at terminal count, cleared on frame start.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         if (tick_o) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + TW'(1);
         end
      end else begin
         cnt_q <= cnt_q;
      end
   end

endmodule

// File: rtl/byte_serial_tx.sv
// UART-style byte transmitter: start, 8 data bits LSB first, optional even parity, stop.
module byte_serial_tx
   import byte_serial_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 32'd4,
   parameter bit          PARITY_EN    = 1'b0
) (
   input  logic           clock,
   input  logic           reset,
   byte_serial_tx_if.slave dif,
   output logic           tx,
   output logic           busy,
   output logic           done
);

   localparam int unsigned   TW       = timer_w(CLKS_PER_BIT);
   // With one cycle per bit the stop bit is a single cycle, so done is set on entry.
   localparam logic          ONE_CLK  = (CLKS_PER_BIT == 32'd1);
   localparam logic [TW-1:0] PRE_LAST = TW'((CLKS_PER_BIT > 32'd1) ? (CLKS_PER_BIT - 32'd2) : 32'd0);

   state_e            state_q;
   logic              tx_q;
   logic              busy_q;
   logic              ready_q;
   logic              done_q;
   logic [2:0]        bit_cnt_q;
   logic [DATA_W-1:0] shift_q;
   logic              parity_q;

   logic              accept_s;
   logic              tick_s;
   logic [TW-1:0]     cnt_s;
   logic              stop_pre_last_s;

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk_i  (clock),
      .rst_ni (reset),
      .clr_i  (accept_s),
      .en_i   (busy_q),
      .tick_o (tick_s),
      .cnt_o  (cnt_s)
   );

   // Handshake acceptance and look-ahead to the final stop-bit cycle.
   always_comb begin
      accept_s        = (state_q == IDLE) && ready_q && dif.din_valid;
      stop_pre_last_s = (cnt_s == PRE_LAST);
   end

   // Frame sequencer with registered line, status and handshake outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         tx_q      <= IDLE_LEVEL;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         bit_cnt_q <= 3'd0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_q      <= IDLE_LEVEL;
               busy_q    <= 1'b0;
               bit_cnt_q <= 3'd0;
               if (accept_s) begin
                  shift_q  <= dif.Din;
                  parity_q <= even_parity(dif.Din);
                  state_q  <= START;
                  tx_q     <= START_LEVEL;
                  busy_q   <= 1'b1;
                  ready_q  <= 1'b0;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            START: begin
               if (tick_s) begin
                  state_q <= DATA;
                  tx_q    <= shift_q[0];
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (bit_cnt_q == 3'd7) begin
                     bit_cnt_q <= 3'd0;
                     if (PARITY_EN) begin
                        state_q <= PARITY;
                        tx_q    <= parity_q;
                     end else begin
                        state_q <= STOP;
                        tx_q    <= IDLE_LEVEL;
                        done_q  <= ONE_CLK;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
                     tx_q      <= shift_q[1];
                  end
               end
            end
            PARITY: begin
               if (tick_s) begin
                  state_q <= STOP;
                  tx_q    <= IDLE_LEVEL;
                  done_q  <= ONE_CLK;
               end
            end
            STOP: begin
               if (tick_s) begin
                  state_q <= IDLE;
                  tx_q    <= IDLE_LEVEL;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  done_q <= stop_pre_last_s;
               end
            end
            default: begin
               state_q   <= IDLE;
               tx_q      <= IDLE_LEVEL;
               busy_q    <= 1'b0;
               ready_q   <= 1'b0;
               bit_cnt_q <= 3'd0;
            end
         endcase
      end
   end

   assign dif.din_ready = ready_q;
   assign tx            = tx_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Self-checking bench: three transmitter configurations against a frame-level model.
module tb_byte_serial_tx;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din_r [3];
   logic [2:0] valid_r;
   wire  [2:0] tx_w;
   wire  [2:0] busy_w;
   wire  [2:0] done_w;
   wire  [2:0] rdy_w;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   byte_serial_tx_if if0 ();
   byte_serial_tx_if if1 ();
   byte_serial_tx_if if2 ();

   assign if0.Din = din_r[0];  assign if0.din_valid = valid_r[0];  assign rdy_w[0] = if0.din_ready;
   assign if1.Din = din_r[1];  assign if1.din_valid = valid_r[1];  assign rdy_w[1] = if1.din_ready;
   assign if2.Din = din_r[2];  assign if2.din_valid = valid_r[2];  assign rdy_w[2] = if2.din_ready;

   byte_serial_tx #(.CLKS_PER_BIT(32'd4), .PARITY_EN(1'b0)) dut0 (
      .clock(clk), .reset(rst_n), .dif(if0), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   byte_serial_tx #(.CLKS_PER_BIT(32'd4), .PARITY_EN(1'b1)) dut1 (
      .clock(clk), .reset(rst_n), .dif(if1), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   byte_serial_tx #(.CLKS_PER_BIT(32'd1), .PARITY_EN(1'b0)) dut2 (
      .clock(clk), .reset(rst_n), .dif(if2), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

   function automatic int cpb(input logic [1:0] k);
      return (k == 2'd2) ? 1 : 4;
   endfunction

   function automatic bit par(input logic [1:0] k);
      return (k == 2'd1);
   endfunction

   task automatic check(input string tag, input logic [1:0] k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_state(input string tag, input logic [1:0] k, input logic rdy);
      check({tag, "_tx"},    k, 32'(tx_w[k]),   32'd1);
      check({tag, "_busy"},  k, 32'(busy_w[k]), 32'd0);
      check({tag, "_ready"}, k, 32'(rdy_w[k]),  32'(rdy));
      check({tag, "_done"},  k, 32'(done_w[k]), 32'd0);
   endtask

   // Send one byte and check every cycle of the frame against the expected line levels.
   task automatic frame(input logic [1:0] k, input logic [7:0] b, input bit keep_valid, input bit scramble);
      bit lv[$];
      int c = cpb(k);
      int n = 0;
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(b[i]);
      if (par(k)) lv.push_back(^b);
      lv.push_back(1'b1);
      din_r[k]   = b;
      valid_r[k] = 1'b1;
      while (rdy_w[k] !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      check("ready_wait", k, 32'(n < 100), 32'd1);
      step();
      if (!keep_valid) valid_r[k] = 1'b0;
      for (int j = 0; j < lv.size(); j++) begin
         for (int t = 0; t < c; t++) begin
            check("tx",        k, 32'(tx_w[k]),   32'(lv[j]));
            check("busy",      k, 32'(busy_w[k]), 32'd1);
            check("ready_mid", k, 32'(rdy_w[k]),  32'd0);
            check("done",      k, 32'(done_w[k]), 32'((j == lv.size() - 1) && (t == c - 1)));
            if (scramble) din_r[k] = 8'($urandom);
            step();
         end
      end
      idle_state("after", k, 1'b1);
   endtask

   initial begin
      logic [7:0] b;
      for (int k = 0; k < 3; k++) din_r[k] = 8'h00;
      valid_r = 3'b000;
      rst_n   = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 3; k++) idle_state("reset", 2'(k), 1'b0);
      rst_n = 1'b1;
      step();
      for (int k = 0; k < 3; k++) idle_state("release", 2'(k), 1'b1);

      // Directed frames from the plan.
      frame(2'd0, 8'b10011000, 1'b0, 1'b0);
      frame(2'd1, 8'b11111100, 1'b0, 1'b0);
      frame(2'd1, 8'b10011110, 1'b0, 1'b0);
      frame(2'd2, 8'hFF,       1'b0, 1'b0);

      // Back-to-back with valid held: one idle cycle, then the second byte.
      frame(2'd0, 8'hA5, 1'b1, 1'b0);
      frame(2'd0, 8'h3C, 1'b0, 1'b0);
      frame(2'd2, 8'h5A, 1'b1, 1'b0);
      frame(2'd2, 8'hC3, 1'b0, 1'b0);

      // Din changing every cycle mid-frame.
      for (int k = 0; k < 3; k++) frame(2'(k), 8'($urandom), 1'b0, 1'b1);

      // Random bytes on every configuration.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 3; k++) frame(2'(k), 8'($urandom), 1'b0, 1'b0);
      end

      // Reset in the middle of data bit 3.
      b = 8'($urandom);
      din_r[0]   = b;
      valid_r[0] = 1'b1;
      step();
      repeat (16) step();
      check("bit3", 2'd0, 32'(tx_w[0]), 32'(b[3]));
      rst_n = 1'b0;
      step();
      idle_state("midreset", 2'd0, 1'b0);
      step();
      idle_state("midreset_hold", 2'd0, 1'b0);
      rst_n      = 1'b1;
      valid_r[0] = 1'b0;
      step();
      idle_state("midreset_release", 2'd0, 1'b1);
      frame(2'd0, 8'h81, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
